pixel_result_queue: RTL and testbench

- Sits directly downstream of the trace_path core and upstream of color_transmitter (UART) and the VGA framebuffer write port.
- Captures each finished pixel (x, y, 24-bit RGB) on the rising edge of the core's done level and buffers it in a small FIFO, so the tracer is not stalled by the slow UART.
- Drains one entry at a time: a one-cycle UART start pulse plus a one-cycle framebuffer write strobe carrying packed RGB332.

---
 rtl/pixel_result_queue.sv | 151 +++++++++++++++
 tb/tb_pixel_result_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_result_queue.sv
// pixel_result_queue
//   Buffers finished pixels from the trace_path core and drains them one at a
//   time to the UART color_transmitter and the VGA framebuffer write port.
//
//   A pixel is captured on the rising edge of in_done. Each pop produces a
//   one-cycle tx_start and a one-cycle fb_we pulse. The colour, coordinates
//   and RGB332 pixel stay valid from that pop until the next pop.
//
//   Parameters: DEPTH (FIFO entries, power of 2, >= 2), XW, YW (coordinate widths)
//
//   Ports:
//     clk, reset_n            clock, async active-low reset
//     in_done/in_x/in_y/in_rgb tracer result (level done, data valid while high)
//     tx_busy                 transmitter busy (input)
//     tx_start, tx_rgb        transmitter start pulse + colour
//     fb_we, fb_x, fb_y, fb_pix framebuffer write strobe, address, RGB332 pixel
//     empty, full, count      FIFO status
//     overflow                sticky: a pixel was dropped because the FIFO was full
//     checksum                running R+G+B sum of popped pixels
//
//   Optional feature macro: PIXQ_CHECKSUM_EN. When it is undefined, checksum
//   is tied to 0 and the adder is not built.

module pixel_result_queue #(
  parameter int DEPTH = 16,
  parameter int XW    = 8,
  parameter int YW    = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_done,
  input  logic [XW-1:0]            in_x,
  input  logic [YW-1:0]            in_y,
  input  logic [23:0]              in_rgb,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [23:0]              tx_rgb,
  output logic                     fb_we,
  output logic [XW-1:0]            fb_x,
  output logic [YW-1:0]            fb_y,
  output logic [7:0]               fb_pix,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              checksum
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [23:0]   rgb;
  } pix_t;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_t;

  pix_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_done_q;
  logic          r_overflow;
  state_t        r_state;

  logic          w_push, w_full, w_empty, w_wr, w_pop;
  pix_t          w_head;

  assign w_push  = in_done & ~r_done_q;
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // Full check uses the pre-edge count, so a push that coincides with a pop
  // on a full FIFO is still dropped.
  assign w_wr    = w_push & ~w_full;
  assign w_pop   = (r_state == IDLE) & ~w_empty & ~tx_busy;
  assign w_head  = r_mem[r_rd_ptr];

  // FIFO storage (no reset needed; validity tracked by r_count)
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= '{x: in_x, y: in_y, rgb: in_rgb};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done_q   <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done_q <= in_done;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      if (w_push & w_full) r_overflow <= 1'b1;
    end
  end

  // Drain FSM with registered strobes and data outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      tx_start <= 1'b0;
      fb_we    <= 1'b0;
      tx_rgb   <= '0;
      fb_x     <= '0;
      fb_y     <= '0;
      fb_pix   <= '0;
    end else begin
      tx_start <= 1'b0;
      fb_we    <= 1'b0;
      case (r_state)
        IDLE: if (w_pop) begin
          tx_rgb   <= w_head.rgb;
          fb_x     <= w_head.x;
          fb_y     <= w_head.y;
          fb_pix   <= {w_head.rgb[23:21], w_head.rgb[15:13], w_head.rgb[7:6]};
          // Strobes rise together with the ISSUE state.
          tx_start <= 1'b1;
          fb_we    <= 1'b1;
          r_state  <= ISSUE;
        end
        ISSUE:   r_state <= HOLD;
        // One cycle for the transmitter to raise busy before it is sampled.
        HOLD:    r_state <= WAIT;
        WAIT:    if (!tx_busy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef PIXQ_CHECKSUM_EN
  logic [15:0] r_checksum;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_checksum <= '0;
    else if (w_pop) r_checksum <= r_checksum + 16'(w_head.rgb[23:16])
                                             + 16'(w_head.rgb[15:8])
                                             + 16'(w_head.rgb[7:0]);
  end
  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_pixel_result_queue.sv
// Directed bench for pixel_result_queue (DEPTH=16, XW=YW=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_pixel_result_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_done = 1'b0;
  logic [7:0]  in_x = '0, in_y = '0;
  logic [23:0] in_rgb = '0;
  logic        tx_busy = 1'b0;
  logic        tx_start, fb_we, empty, full, overflow;
  logic [23:0] tx_rgb;
  logic [7:0]  fb_x, fb_y, fb_pix;
  logic [4:0]  count;
  logic [15:0] checksum;

  int n_chk = 0;
  int n_err = 0;

  logic [23:0] q_rgb[$];
  logic [7:0]  q_x[$];
  int          n_pair_bad;
  int          max_cnt;

  pixel_result_queue #(.DEPTH(16), .XW(8), .YW(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_done(in_done), .in_x(in_x), .in_y(in_y),
    .in_rgb(in_rgb), .tx_busy(tx_busy), .tx_start(tx_start), .tx_rgb(tx_rgb),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_pix(fb_pix), .empty(empty),
    .full(full), .count(count), .overflow(overflow), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_done = 1'b0; tx_busy = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One-cycle done pulse followed by one low cycle, so the next pulse is a new edge.
  task automatic pulse(input logic [7:0] x, input logic [7:0] y, input logic [23:0] rgb);
    @(negedge clk);
    in_done = 1'b1; in_x = x; in_y = y; in_rgb = rgb;
    @(negedge clk);
    in_done = 1'b0;
  endtask

  // Runs 'cycles' falling edges acting as the transmitter: raises busy for 3
  // cycles after each start. Records popped data; in_done is held high for
  // the first 'hold' cycles.
  task automatic drain(input int cycles, input int hold);
    int bc;
    bc = 0;
    q_rgb.delete(); q_x.delete();
    n_pair_bad = 0; max_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx_start) begin
        q_rgb.push_back(tx_rgb); q_x.push_back(fb_x); bc = 3;
      end
      if (tx_start !== fb_we) n_pair_bad++;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      tx_busy = (bc > 0);
      if (bc > 0) bc--;
      in_done = (i < hold);
    end
    tx_busy = 1'b0; in_done = 1'b0;
  endtask

`ifdef PIXQ_CHECKSUM_EN
  localparam logic [15:0] CS1 = 16'h0006;  // 01+02+03
  localparam logic [15:0] CS2 = 16'h0303;  // 6 + 3*FF
`else
  localparam logic [15:0] CS1 = 16'h0000;
  localparam logic [15:0] CS2 = 16'h0000;
`endif

  initial begin
    // ---------------- reset state
    @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_txs", tx_start, 0);
    chk("rst_fbwe", fb_we, 0);
    chk("rst_txrgb", tx_rgb, 0);
    chk("rst_fbpix", fb_pix, 0);
    chk("rst_cs", checksum, 0);
    reset_n = 1'b1;

    // ---------------- single pixel, exact timing
    @(negedge clk);
    in_done = 1'b1; in_x = 8'd5; in_y = 8'd7; in_rgb = 24'hFF8040;   // cycle 0
    @(negedge clk);                                                  // cycle 1
    in_done = 1'b0;
    chk("sp_c1_txs", tx_start, 0);
    chk("sp_c1_cnt", count, 1);
    @(negedge clk);                                                  // cycle 2
    chk("sp_c2_txs", tx_start, 1);
    chk("sp_c2_fbwe", fb_we, 1);
    chk("sp_rgb", tx_rgb, 24'hFF8040);
    chk("sp_x", fb_x, 5);
    chk("sp_y", fb_y, 7);
    // R=FF->111, G=80->100, B=40->01 : 1111_0001
    chk("sp_pix", fb_pix, 8'hF1);
    chk("sp_cnt0", count, 0);
    @(negedge clk);                                                  // cycle 3
    chk("sp_c3_txs", tx_start, 0);
    chk("sp_c3_fbwe", fb_we, 0);
    chk("sp_hold_rgb", tx_rgb, 24'hFF8040);

    // ---------------- level hold: 10 cycles high -> one push, one start
    do_reset();
    in_x = 8'd9; in_rgb = 24'h123456;
    drain(30, 10);
    chk("lh_starts", q_rgb.size(), 1);
    chk("lh_maxcnt", max_cnt, 1);
    chk("lh_pair", n_pair_bad, 0);

    // ---------------- backpressure and fill: 17 pulses into 16 entries
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 17; i++) pulse(8'(i), 8'(i + 100), {8'(i), 8'hA5, 8'(255 - i)});
    @(negedge clk);
    chk("bp_full", full, 1);
    chk("bp_cnt", count, 16);
    chk("bp_ovf", overflow, 1);
    chk("bp_txs", tx_start, 0);
    drain(120, 0);
    chk("bp_nout", q_rgb.size(), 16);
    for (int i = 0; i < 16 && i < q_rgb.size(); i++) begin
      chk($sformatf("bp_rgb%0d", i), q_rgb[i], {8'(i), 8'hA5, 8'(255 - i)});
      chk($sformatf("bp_x%0d", i), q_x[i], 8'(i));
    end
    chk("bp_empty", empty, 1);
    chk("bp_ovf_sticky", overflow, 1);
    chk("bp_pair", n_pair_bad, 0);

    // ---------------- simultaneous push/pop at count=3
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) pulse(8'(i), 8'd0, 24'h000001);
    @(negedge clk);
    chk("pp3_pre", count, 3);
    tx_busy = 1'b0; in_done = 1'b1;
    @(negedge clk);
    tx_busy = 1'b1; in_done = 1'b0;
    chk("pp3_cnt", count, 3);
    chk("pp3_txs", tx_start, 1);
    chk("pp3_ovf", overflow, 0);

    // ---------------- simultaneous push/pop at count=16 (push dropped)
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) pulse(8'(i), 8'd0, 24'h000001);
    @(negedge clk);
    chk("pp16_pre", count, 16);
    chk("pp16_ovf_pre", overflow, 0);
    tx_busy = 1'b0; in_done = 1'b1;
    @(negedge clk);
    tx_busy = 1'b1; in_done = 1'b0;
    chk("pp16_cnt", count, 15);
    chk("pp16_ovf", overflow, 1);
    chk("pp16_full", full, 0);

    // ---------------- reset while in WAIT with count=4
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) pulse(8'(i + 1), 8'd3, 24'h445566);
    @(negedge clk);
    tx_busy = 1'b0;                 // one pop -> ISSUE
    @(negedge clk);
    tx_busy = 1'b1;                 // HOLD then WAIT, stuck on busy
    chk("mr_txs", tx_start, 1);
    @(negedge clk);
    @(negedge clk);
    chk("mr_cnt4", count, 4);
    reset_n = 1'b0;
    #1;
    chk("mr_cnt", count, 0);
    chk("mr_empty", empty, 1);
    chk("mr_rgb", tx_rgb, 0);
    chk("mr_fbx", fb_x, 0);
    chk("mr_fby", fb_y, 0);
    chk("mr_pix", fb_pix, 0);
    @(negedge clk);
    reset_n = 1'b1; tx_busy = 1'b0;
    drain(12, 0);
    chk("mr_nostart", q_rgb.size(), 0);
    pulse(8'd42, 8'd1, 24'h0000FF);
    drain(8, 0);
    chk("mr_new", q_rgb.size(), 1);

    // ---------------- checksum
    do_reset();
    pulse(8'd1, 8'd1, 24'h010203);
    drain(8, 0);
    chk("cs1", checksum, CS1);
    pulse(8'd2, 8'd2, 24'hFFFFFF);
    drain(8, 0);
    chk("cs2", checksum, CS2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
